// File: rtl/de1_soc_hps_master_stream_arbiter.sv
// Round-robin, packet-locked arbiter for the byte stream feeding the HPS master
// timing adapter; an idle watchdog reclaims the stream from a stalled owner.
module de1_soc_hps_master_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 256,
    parameter int CNT_W        = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     in_valid,
    input  logic [8*NUM_REQ-1:0]   in_data,
    input  logic [NUM_REQ-1:0]     in_sop,
    input  logic [NUM_REQ-1:0]     in_eop,
    output logic [NUM_REQ-1:0]     in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    input  logic                   out_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout_err
);
    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]   NREQ     = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ-1);
    localparam logic [CNT_W-1:0] WD_LAST  = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT-1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic               sel_valid, sel_sop, sel_eop;
    logic [7:0]         sel_data;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   rr_next;

    // Owner's stream, selected by the registered owner index.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                sel_valid = in_valid[i];
                sel_data  = in_data[8*i +: 8];
                sel_sop   = in_sop[i];
                sel_eop   = in_eop[i];
            end
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && in_valid[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    assign rr_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
        out_valid     = 1'b0;
        out_data      = '0;
        out_sop       = 1'b0;
        out_eop       = 1'b0;
        in_ready      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = BUSY;
                    owner_d  = pick;
                    grant_d  = NUM_REQ'(1) << pick;
                    wd_cnt_d = '0;
                end
            end
            BUSY: begin
                out_valid = sel_valid;
                out_data  = sel_data;
                out_sop   = sel_sop;
                out_eop   = sel_eop;
                in_ready  = out_ready ? grant_q : '0;
                // An EOP transfer always releases first, so it beats a coincident timeout.
                if (sel_valid && out_ready && sel_eop) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = rr_next;
                    wd_cnt_d = '0;
                end else if (IDLE_TIMEOUT > 0) begin
                    if (sel_valid) begin
                        wd_cnt_d = '0;
                    end else if (wd_cnt_q == WD_LAST) begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        rr_ptr_d      = rr_next;
                        wd_cnt_d      = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;
endmodule
